// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for the 8:1 mux path: drives a latched word onto the mux inputs,
// walks the select lines, samples the mux output per index and flags a match.
module mux_scan_ctrl #(
    parameter int SEL_W = 3,
    parameter int DWELL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2**SEL_W-1:0]   data_in,
    input  logic                  y_in,
    output logic [2**SEL_W-1:0]   data_out,
    output logic [SEL_W-1:0]      sel,
    output logic                  busy,
    output logic                  done,
    output logic [2**SEL_W-1:0]   captured,
    output logic                  match
);

    localparam int N = 2**SEL_W;
    localparam logic [3:0] CNT_RELOAD = 4'(DWELL - 1);

    if (DWELL < 1 || DWELL > 15) begin : g_dwell_check
        $error("mux_scan_ctrl: DWELL must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    // state and cnt are kept as named internal signals so checkers can bind to them.
    state_t     state;
    logic [3:0] cnt;
    logic [N-1:0] captured_next;

    always_comb begin
        captured_next      = captured;
        captured_next[sel] = y_in;
    end

    // Handshake: start is a request honoured only in IDLE; busy is high from the
    // accepting edge until DONE is entered; done pulses for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            data_out <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            captured <= '0;
            match    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        data_out <= data_in;
                        sel      <= '0;
                        captured <= '0;
                        match    <= 1'b0;
                        cnt      <= CNT_RELOAD;
                        busy     <= 1'b1;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == 4'd0) state <= SAMPLE;
                    else             cnt   <= cnt - 4'd1;
                end
                SAMPLE: begin
                    captured <= captured_next;
                    if (sel == '1) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        match <= (captured_next == data_out);
                        state <= DONE;
                    end else begin
                        sel   <= sel + 1'b1;
                        cnt   <= CNT_RELOAD;
                        state <= SETTLE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: behavioural mux feeds y_in back, completed scans are
// checked against an expected queue filled when each start is issued.
module tb_mux_scan_ctrl;

    localparam int N  = 8;
    localparam int EW = 32 + N + 1;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // default instance (DWELL=1)
    logic         start, y_in, busy, done, match, force_y0;
    logic [N-1:0] data_in, data_out, captured;
    logic [2:0]   sel;

    // DWELL=3 instance
    logic         start3, y3, busy3, done3, match3;
    logic [N-1:0] data3, data_out3, captured3;
    logic [2:0]   sel3;

    assign y_in = (force_y0 && sel == 3'd7) ? 1'b0 : data_out[sel];
    assign y3   = data_out3[sel3];

    mux_scan_ctrl #(.SEL_W(3), .DWELL(1)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .y_in(y_in),
        .data_out(data_out), .sel(sel), .busy(busy), .done(done),
        .captured(captured), .match(match)
    );

    mux_scan_ctrl #(.SEL_W(3), .DWELL(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .data_in(data3), .y_in(y3),
        .data_out(data_out3), .sel(sel3), .busy(busy3), .done(done3),
        .captured(captured3), .match(match3)
    );

    // entry = {done cycle, captured, match}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp3_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_idle_zero();
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_sel",      32'(sel),      32'h0);
        check("rst_busy",     32'(busy),     32'h0);
        check("rst_done",     32'(done),     32'h0);
        check("rst_captured", 32'(captured), 32'h0);
        check("rst_match",    32'(match),    32'h0);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("done_cycle",  32'(cyc),      e[EW-1 -: 32]);
                check("captured",    32'(captured), 32'(e[N:1]));
                check("match",       32'(match),    32'(e[0]));
                check("busy_in_done", 32'(busy),    32'h0);
                check("sel_in_done", 32'(sel),      32'h7);
            end
        end
    end

    always @(negedge clk) begin
        if (done3) begin
            if (exp3_q.size() == 0) begin
                check("unexpected_done3", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                logic [EW-1:0] e;
                e = exp3_q.pop_front();
                check("done3_cycle", 32'(cyc),       e[EW-1 -: 32]);
                check("captured3",   32'(captured3), 32'(e[N:1]));
                check("match3",      32'(match3),    32'(e[0]));
                check("busy3_in_done", 32'(busy3),   32'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int s;
        rst = 1'b1; start = 1'b0; data_in = '0; force_y0 = 1'b0;
        start3 = 1'b0; data3 = '0;
        repeat (3) @(negedge clk);
        check_idle_zero();
        rst = 1'b0;
        @(negedge clk);

        // Scans 1+2: start held high; second word latched on re-accept after DONE.
        data_in = 8'b0100_0100;
        start   = 1'b1;
        s = cyc + 1;
        exp_q.push_back({32'(s + 16), 8'h44, 1'b1});
        exp_q.push_back({32'(s + 34), 8'hC4, 1'b1});
        for (int t = 0; t <= 16; t++) begin
            @(negedge clk);
            if (t == 0) data_in = 8'b1100_0100;
            check("scan1_sel",  32'(sel),  32'((t / 2 > 7) ? 7 : t / 2));
            check("scan1_busy", 32'(busy), 32'(t < 16));
        end
        @(negedge clk);
        check("idle_after_done_busy", 32'(busy), 32'h0);
        @(negedge clk);
        start = 1'b0;
        check("scan2_data_out", 32'(data_out), 32'hC4);
        check("scan2_busy",     32'(busy),     32'h1);
        repeat (18) @(negedge clk);

        // Fault: y forced low at sel=7.
        force_y0 = 1'b1;
        data_in  = 8'hC4;
        start    = 1'b1;
        s = cyc + 1;
        exp_q.push_back({32'(s + 16), 8'h44, 1'b0});
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);
        force_y0 = 1'b0;

        // Busy protection: start re-pulsed at t=5 and t=15, data_in changed mid-scan.
        data_in = 8'h5A;
        start   = 1'b1;
        s = cyc + 1;
        exp_q.push_back({32'(s + 16), 8'h5A, 1'b1});
        for (int t = 0; t <= 20; t++) begin
            @(negedge clk);
            start = (t == 4 || t == 14);
            if (t == 0) data_in = 8'hFF;
            if (t == 5)  check("busy_prot_sel5",  32'(sel), 32'h2);
            if (t == 15) check("busy_prot_sel15", 32'(sel), 32'h7);
            if (t == 5)  check("busy_prot_data",  32'(data_out), 32'h5A);
        end

        // Reset mid-scan at sel=3: no done expected.
        data_in = 8'h3C;
        start   = 1'b1;
        for (int t = 0; t <= 6; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_reset_sel", 32'(sel), 32'h3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero();
        repeat (20) @(negedge clk);

        data_in = 8'h81;
        start   = 1'b1;
        s = cyc + 1;
        exp_q.push_back({32'(s + 16), 8'h81, 1'b1});
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);

        // DWELL=3 instance.
        data3  = 8'hA5;
        start3 = 1'b1;
        s = cyc + 1;
        exp3_q.push_back({32'(s + 32), 8'hA5, 1'b1});
        @(negedge clk);
        start3 = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            if (t == 4) check("dwell3_sel_t4", 32'(sel3), 32'h1);
            if (t == 8) check("dwell3_sel_t8", 32'(sel3), 32'h2);
        end
        repeat (30) @(negedge clk);

        check("exp_q_drained",  32'(exp_q.size()),  32'h0);
        check("exp3_q_drained", 32'(exp3_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
